// File: rtl/uart_vga_pkg.sv
// Shared types and defaults for the UART-to-display-RAM row loader.
// Used by uart_rx_byte and uart_vga_loader (optional build macro UART_VGA_LOADER_CHECKSUM_EN).
package uart_vga_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    P_SYNC,
    P_ROW,
    P_DATA,
    P_CHK,
    P_FLUSH
  } pkt_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF     = 8'hA5;
  localparam int         ROWS_DEF          = 46;
  localparam int         BYTES_PER_ROW_DEF = 20;

  // First RAM byte address of a display row, zero-extended to 32 bits.
  function automatic logic [31:0] row_base(input logic [7:0] row, input int unsigned bpr);
    return 32'(row) * 32'(bpr);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-FF synchronizer, 8N1 receive FSM and stop-bit framing check.
// Strobe contract: byte_valid and frame_err are single-cycle pulses with no
// back-pressure; byte_data is valid in the same cycle as byte_valid and the
// consumer must take it then (valid-only, there is no ready).
module uart_rx_byte
  import uart_vga_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta, rx_sync;
  rx_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shreg, shreg_next;
  logic          valid_next, err_next;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= R_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_next;
      shreg      <= shreg_next;
      byte_valid <= valid_next;
      frame_err  <= err_next;
    end
  end

  // Next-state: mid-start-bit glitch filter, then one sample per bit period.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shreg_next = shreg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    case (state)
      R_IDLE: begin
        cnt_next = '0;
        if (!rx_sync) state_next = R_START;
      end
      R_START: begin
        if (cnt == HALF) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rx_sync ? R_IDLE : R_DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt == LAST) begin
          cnt_next   = '0;
          shreg_next = {rx_sync, shreg[7:1]};
          if (bit_idx == 3'd7) state_next = R_STOP;
          else                 bit_next   = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt == LAST) begin
          cnt_next   = '0;
          state_next = R_IDLE;
          if (rx_sync) valid_next = 1'b1;
          else         err_next   = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = R_IDLE;
    endcase
  end

  assign byte_data = shreg;

endmodule

// File: rtl/uart_vga_loader.sv
// Packet parser feeding the display RAM write port: A5, row, 20 data bytes.
// Build macro UART_VGA_LOADER_CHECKSUM_EN buffers the row, checks a trailing
// XOR checksum and writes the row as a 20-cycle burst only on a match.
module uart_vga_loader
  import uart_vga_pkg::*;
#(
  parameter int         CLKS_PER_BIT  = 87,
  parameter int         ROWS          = ROWS_DEF,
  parameter int         BYTES_PER_ROW = BYTES_PER_ROW_DEF,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] write_address,
  output logic [7:0]  ram_in,
  output logic        we,
  output logic        row_done,
  output logic        pkt_err
);

  localparam int            IW       = $clog2(BYTES_PER_ROW);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_ROW - 1);

  logic        byte_valid, frame_err;
  logic [7:0]  byte_data;

  pkt_state_t    state, state_next;
  logic [7:0]    row, row_next;
  logic [IW-1:0] idx, idx_next;
  logic          we_next, done_pend, done_pend_next, err_next;
  logic [7:0]    ram_in_next;
  logic [31:0]   addr_next;

`ifdef UART_VGA_LOADER_CHECKSUM_EN
  logic [7:0] chk, chk_next;
  logic       buf_we;
  logic [7:0] row_buf [BYTES_PER_ROW];
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  // Packet FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= P_SYNC;
    else     state <= state_next;
  end

  // Registered RAM port and status pulses; row_done trails the final write by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row           <= '0;
      idx           <= '0;
      we            <= 1'b0;
      ram_in        <= '0;
      write_address <= '0;
      done_pend     <= 1'b0;
      row_done      <= 1'b0;
      pkt_err       <= 1'b0;
    end else begin
      row           <= row_next;
      idx           <= idx_next;
      we            <= we_next;
      ram_in        <= ram_in_next;
      write_address <= addr_next;
      done_pend     <= done_pend_next;
      row_done      <= done_pend;
      pkt_err       <= err_next;
    end
  end

`ifdef UART_VGA_LOADER_CHECKSUM_EN
  // Running checksum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk <= '0;
    else     chk <= chk_next;
  end

  // Row staging buffer; contents only matter after a full row was received.
  always_ff @(posedge clk) begin
    if (buf_we) row_buf[idx] <= byte_data;
  end
`endif

  // Packet next-state and RAM write decode.
  always_comb begin
    state_next     = state;
    row_next       = row;
    idx_next       = idx;
    we_next        = 1'b0;
    ram_in_next    = ram_in;
    addr_next      = write_address;
    done_pend_next = 1'b0;
    err_next       = 1'b0;
`ifdef UART_VGA_LOADER_CHECKSUM_EN
    chk_next       = chk;
    buf_we         = 1'b0;
`endif
    case (state)
      P_SYNC: begin
        if (frame_err) err_next = 1'b1;
        else if (byte_valid && byte_data == SYNC_BYTE) state_next = P_ROW;
      end
      P_ROW: begin
        if (frame_err) begin
          err_next   = 1'b1;
          state_next = P_SYNC;
        end else if (byte_valid) begin
          if (32'(byte_data) >= 32'(ROWS)) begin
            err_next   = 1'b1;
            state_next = P_SYNC;
          end else begin
            row_next   = byte_data;
            idx_next   = '0;
            state_next = P_DATA;
`ifdef UART_VGA_LOADER_CHECKSUM_EN
            chk_next   = byte_data;
`endif
          end
        end
      end
      P_DATA: begin
        if (frame_err) begin
          err_next   = 1'b1;
          state_next = P_SYNC;
        end else if (byte_valid) begin
`ifdef UART_VGA_LOADER_CHECKSUM_EN
          buf_we   = 1'b1;
          chk_next = chk ^ byte_data;
          if (idx == LAST_IDX) state_next = P_CHK;
          else                 idx_next   = idx + 1'b1;
`else
          we_next     = 1'b1;
          ram_in_next = byte_data;
          addr_next   = row_base(row, BYTES_PER_ROW) + 32'(idx);
          if (idx == LAST_IDX) begin
            done_pend_next = 1'b1;
            state_next     = P_SYNC;
          end else begin
            idx_next = idx + 1'b1;
          end
`endif
        end
      end
`ifdef UART_VGA_LOADER_CHECKSUM_EN
      P_CHK: begin
        if (frame_err) begin
          err_next   = 1'b1;
          state_next = P_SYNC;
        end else if (byte_valid) begin
          if (byte_data == chk) begin
            idx_next   = '0;
            state_next = P_FLUSH;
          end else begin
            err_next   = 1'b1;
            state_next = P_SYNC;
          end
        end
      end
      P_FLUSH: begin
        we_next     = 1'b1;
        ram_in_next = row_buf[idx];
        addr_next   = row_base(row, BYTES_PER_ROW) + 32'(idx);
        if (idx == LAST_IDX) begin
          done_pend_next = 1'b1;
          state_next     = P_SYNC;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
`endif
      default: state_next = P_SYNC;
    endcase
  end

endmodule

// File: tb/tb_uart_vga_loader.sv
// Self-checking bench for uart_vga_loader; follows UART_VGA_LOADER_CHECKSUM_EN when defined.
module tb_uart_vga_loader;

  localparam int CPB = 24;

  logic        clk, rst, rx;
  logic [31:0] write_address;
  logic [7:0]  ram_in;
  logic        we, row_done, pkt_err;

  uart_vga_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .write_address (write_address),
    .ram_in        (ram_in),
    .we            (we),
    .row_done      (row_done),
    .pkt_err       (pkt_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [39:0] exp_q[$];        // {address, data} in expected write order
  logic [7:0]  data_q[$];       // data bytes of the next packet
  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int we_run   = 0;
  int max_run  = 0;
  logic prev_we  = 1'b0;
  logic prev_end = 1'b0;

  // Monitor: every write must match the scoreboard head; row_done must follow
  // a row's final byte (address % 20 == 19) by exactly one cycle.
  always @(negedge clk) begin
    logic [39:0] exp;
    if (rst) begin
      prev_we  = 1'b0;
      prev_end = 1'b0;
      we_run   = 0;
    end else begin
      if (we) begin
        we_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write", write_address, ram_in);
        end else begin
          exp = exp_q.pop_front();
          if ({write_address, ram_in} !== exp)
            $display("FAIL write_data: got addr=%0d data=%02h, required addr=%0d data=%02h",
                     write_address, ram_in, exp[39:8], exp[7:0]);
          else n_pass++;
        end
`ifndef UART_VGA_LOADER_CHECKSUM_EN
        n_checks++;
        if (prev_we !== 1'b0) $display("FAIL we_single: got we high two cycles running, required single-cycle we");
        else n_pass++;
`endif
        we_run++;
        if (we_run > max_run) max_run = we_run;
      end else begin
        we_run = 0;
      end
      if (row_done || prev_end) begin
        if (row_done) done_cnt++;
        n_checks++;
        if (row_done !== prev_end)
          $display("FAIL row_done_timing: got row_done=%0b, required %0b", row_done, prev_end);
        else n_pass++;
      end
      if (pkt_err) err_cnt++;
      prev_we  = we;
      prev_end = we && (write_address % 20 == 19);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * CPB) @(posedge clk);
  endtask

  // Sends A5, row, data_q (and the XOR checksum when enabled); queues the
  // expected writes row*20+i when the row is in range.
  task automatic send_packet(input logic [7:0] row, input bit good_chk);
    logic [7:0] chk;
    send_byte(8'hA5, 1'b1);
    send_byte(row, 1'b1);
    chk = row;
    for (int i = 0; i < data_q.size(); i++) begin
      if (good_chk && int'(row) < 46)
        exp_q.push_back({32'(int'(row) * 20 + i), data_q[i]});
      chk = chk ^ data_q[i];
      send_byte(data_q[i], 1'b1);
    end
`ifdef UART_VGA_LOADER_CHECKSUM_EN
    send_byte(good_chk ? chk : ~chk, 1'b1);
`endif
  endtask

  task automatic fill_random();
    data_q.delete();
    for (int i = 0; i < 20; i++) data_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic drain(output bit ok);
    int t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    repeat (30) @(posedge clk);
    ok = (exp_q.size() == 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rx  = 1'b1;
    rst = 1'b1;
    #1;
    n_checks++; if (we !== 1'b0) $display("FAIL reset_we: got %0b, required 0", we); else n_pass++;
    n_checks++; if (write_address !== 32'd0) $display("FAIL reset_addr: got %0d, required 0", write_address); else n_pass++;
    n_checks++; if (ram_in !== 8'd0) $display("FAIL reset_ram_in: got %02h, required 00", ram_in); else n_pass++;
    n_checks++; if (row_done !== 1'b0) $display("FAIL reset_row_done: got %0b, required 0", row_done); else n_pass++;
    n_checks++; if (pkt_err !== 1'b0) $display("FAIL reset_pkt_err: got %0b, required 0", pkt_err); else n_pass++;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_normal();
    int w0 = we_cnt, d0 = done_cnt, e0 = err_cnt;
    bit ok;
    data_q.delete();
    for (int i = 0; i < 20; i++) data_q.push_back(8'(i));
    send_packet(8'd3, 1'b1);
    drain(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL normal_drain: got %0d pending writes, required 0", exp_q.size()); else n_pass++;
    n_checks++; if (we_cnt - w0 !== 20) $display("FAIL normal_writes: got %0d, required 20", we_cnt - w0); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL normal_row_done: got %0d, required 1", done_cnt - d0); else n_pass++;
    n_checks++; if (err_cnt - e0 !== 0) $display("FAIL normal_err: got %0d, required 0", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_bad_row();
    int w0 = we_cnt, e0 = err_cnt, d0;
    bit ok;
    send_byte(8'hA5, 1'b1);
    send_byte(8'd46, 1'b1);
    idle(2);
    n_checks++; if (err_cnt - e0 !== 1) $display("FAIL bad_row_err: got %0d, required 1", err_cnt - e0); else n_pass++;
    n_checks++; if (we_cnt - w0 !== 0) $display("FAIL bad_row_writes: got %0d, required 0", we_cnt - w0); else n_pass++;
    w0 = we_cnt; d0 = done_cnt;
    data_q.delete();
    for (int i = 0; i < 20; i++) data_q.push_back(8'hFF);
    send_packet(8'd0, 1'b1);
    drain(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL bad_row_next_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
    n_checks++; if (we_cnt - w0 !== 20) $display("FAIL bad_row_next_writes: got %0d, required 20", we_cnt - w0); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL bad_row_next_done: got %0d, required 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_framing();
    int w0 = we_cnt, e0 = err_cnt, d0 = done_cnt, exp_w;
    logic [7:0] b;
    bit ok;
`ifdef UART_VGA_LOADER_CHECKSUM_EN
    exp_w = 0;
`else
    exp_w = 5;
`endif
    send_byte(8'hA5, 1'b1);
    send_byte(8'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < exp_w) exp_q.push_back({32'(20 + i), b});
      send_byte(b, 1'b1);
    end
    send_byte(8'h3C, 1'b0);
    idle(3);
    n_checks++; if (we_cnt - w0 !== exp_w) $display("FAIL framing_writes: got %0d, required %0d", we_cnt - w0, exp_w); else n_pass++;
    n_checks++; if (err_cnt - e0 !== 1) $display("FAIL framing_err: got %0d, required 1", err_cnt - e0); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 0) $display("FAIL framing_done: got %0d, required 0", done_cnt - d0); else n_pass++;
    w0 = we_cnt;
    fill_random();
    send_packet(8'd7, 1'b1);
    drain(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL framing_restart_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
    n_checks++; if (we_cnt - w0 !== 20) $display("FAIL framing_restart_writes: got %0d, required 20", we_cnt - w0); else n_pass++;
  endtask

  task automatic test_noise_glitch();
    int w0 = we_cnt, e0 = err_cnt;
    bit ok;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    idle(2);
    rx = 1'b0;
    repeat (10) @(posedge clk);
    rx = 1'b1;
    idle(3);
    n_checks++; if (err_cnt - e0 !== 0) $display("FAIL glitch_err: got %0d, required 0", err_cnt - e0); else n_pass++;
    n_checks++; if (we_cnt - w0 !== 0) $display("FAIL glitch_writes: got %0d, required 0", we_cnt - w0); else n_pass++;
    fill_random();
    send_packet(8'd9, 1'b1);
    drain(ok);
    n_checks++; if (we_cnt - w0 !== 20) $display("FAIL noise_packet_writes: got %0d, required 20", we_cnt - w0); else n_pass++;
    n_checks++; if (ok !== 1'b1) $display("FAIL noise_packet_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_byte();
    int w0 = we_cnt, exp_w;
    logic [7:0] b;
    bit ok;
`ifdef UART_VGA_LOADER_CHECKSUM_EN
    exp_w = 0;
`else
    exp_w = 3;
`endif
    fill_random();
    send_byte(8'hA5, 1'b1);
    send_byte(8'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i < exp_w) exp_q.push_back({32'(100 + i), data_q[i]});
      send_byte(data_q[i], 1'b1);
    end
    b = data_q[3];
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    @(negedge clk);
    n_checks++; if (we_cnt - w0 !== exp_w) $display("FAIL pre_reset_writes: got %0d, required %0d", we_cnt - w0, exp_w); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if ({we, row_done, pkt_err} !== 3'b000) $display("FAIL mid_reset_flags: got %03b, required 000", {we, row_done, pkt_err}); else n_pass++;
    n_checks++; if (write_address !== 32'd0) $display("FAIL mid_reset_addr: got %0d, required 0", write_address); else n_pass++;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    w0 = we_cnt;
    idle(12);
    n_checks++; if (we_cnt - w0 !== 0) $display("FAIL post_reset_writes: got %0d, required 0", we_cnt - w0); else n_pass++;
    fill_random();
    send_packet(8'd11, 1'b1);
    drain(ok);
    n_checks++; if (we_cnt - w0 !== 20) $display("FAIL post_reset_packet: got %0d, required 20", we_cnt - w0); else n_pass++;
  endtask

  task automatic test_random();
    int w0, e0, d0, nb;
    logic [7:0] row, nz;
    bit ok;
    for (int p = 0; p < 3; p++) begin
      w0 = we_cnt; e0 = err_cnt; d0 = done_cnt;
      nb = $urandom_range(0, 2);
      for (int k = 0; k < nb; k++) begin
        nz = 8'($urandom_range(0, 255));
        if (nz == 8'hA5) nz = 8'h5A;
        send_byte(nz, 1'b1);
      end
      row = 8'($urandom_range(0, 45));
      fill_random();
      send_packet(row, 1'b1);
      drain(ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL rand_drain row=%0d: got %0d pending, required 0", row, exp_q.size()); else n_pass++;
      n_checks++; if (we_cnt - w0 !== 20) $display("FAIL rand_writes row=%0d: got %0d, required 20", row, we_cnt - w0); else n_pass++;
      n_checks++; if (done_cnt - d0 !== 1) $display("FAIL rand_done row=%0d: got %0d, required 1", row, done_cnt - d0); else n_pass++;
      n_checks++; if (err_cnt - e0 !== 0) $display("FAIL rand_err row=%0d: got %0d, required 0", row, err_cnt - e0); else n_pass++;
    end
    e0 = err_cnt; w0 = we_cnt;
    row = 8'($urandom_range(46, 255));
    send_byte(8'hA5, 1'b1);
    send_byte(row, 1'b1);
    idle(2);
    n_checks++; if (err_cnt - e0 !== 1) $display("FAIL rand_bad_row=%0d err: got %0d, required 1", row, err_cnt - e0); else n_pass++;
    n_checks++; if (we_cnt - w0 !== 0) $display("FAIL rand_bad_row=%0d writes: got %0d, required 0", row, we_cnt - w0); else n_pass++;
  endtask

`ifdef UART_VGA_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int w0 = we_cnt, e0 = err_cnt;
    bit ok;
    data_q.delete();
    for (int i = 0; i < 20; i++) data_q.push_back(8'h01);
    max_run = 0;
    send_packet(8'd2, 1'b1);
    drain(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL chk_good_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
    n_checks++; if (max_run !== 20) $display("FAIL chk_burst_len: got %0d, required 20", max_run); else n_pass++;
    n_checks++; if (err_cnt - e0 !== 0) $display("FAIL chk_good_err: got %0d, required 0", err_cnt - e0); else n_pass++;
    w0 = we_cnt; e0 = err_cnt;
    send_packet(8'd2, 1'b0);
    idle(2);
    n_checks++; if (err_cnt - e0 !== 1) $display("FAIL chk_bad_err: got %0d, required 1", err_cnt - e0); else n_pass++;
    n_checks++; if (we_cnt - w0 !== 0) $display("FAIL chk_bad_writes: got %0d, required 0", we_cnt - w0); else n_pass++;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_normal();
    test_bad_row();
    test_framing();
    test_noise_glitch();
    test_reset_mid_byte();
    test_random();
`ifdef UART_VGA_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL final_queue: got %0d pending writes, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
